// File: rtl/tdc_multi_channel.sv
// Multi-channel time-to-digital converter: synchronised start/stop edges give
// coarse cycle counts plus a tap-line popcount, queued in a FWFT result FIFO.
module tdc_multi_channel #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned COARSE_W   = 10,
  parameter int unsigned TAPS       = 7,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_CH-1:0]            stop,
  input  logic [NUM_CH*TAPS-1:0]       taps,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1) + COARSE_W + $clog2(TAPS + 1) - 1:0] res_data,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned FINE_W = $clog2(TAPS + 1);
  localparam int unsigned DW     = CH_W + COARSE_W + FINE_W;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam logic [COARSE_W-1:0] C_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic [FINE_W-1:0] popcount(input logic [TAPS-1:0] v);
    logic [FINE_W-1:0] n;
    n = '0;
    for (int i = 0; i < TAPS; i++) n = n + FINE_W'(v[i]);
    return n;
  endfunction

  logic [2:0]             r_start_sync;
  logic [NUM_CH-1:0]      r_stop_s1, r_stop_s2, r_stop_s3;
  logic [NUM_CH*TAPS-1:0] r_taps_s1, r_taps_s2;

  state_t                 r_state;
  logic [COARSE_W-1:0]    r_coarse;
  logic [NUM_CH-1:0]      r_captured;
  logic                   r_done, r_timeout, r_overflow;

  logic [NUM_CH-1:0]      r_pend_valid;
  logic [DW-1:0]          r_pend_data [NUM_CH];

  logic [DW-1:0]          r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]          r_count;

  logic                   w_start_edge, w_start_go, w_window, w_all;
  logic [NUM_CH-1:0]      w_stop_edge, w_prev_cap, w_cap, w_push_sel;
  logic [COARSE_W-1:0]    w_coarse_now;
  logic [DW-1:0]          w_push_data;
  logic                   w_push, w_pop, w_full, w_wr, w_drop;

  // Taps ride alongside the stop synchroniser so they line up with the edge cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_sync <= '0;
      r_stop_s1    <= '0;
      r_stop_s2    <= '0;
      r_stop_s3    <= '0;
      r_taps_s1    <= '0;
      r_taps_s2    <= '0;
    end else begin
      r_start_sync <= {r_start_sync[1:0], start};
      r_stop_s1    <= stop;
      r_stop_s2    <= r_stop_s1;
      r_stop_s3    <= r_stop_s2;
      r_taps_s1    <= taps;
      r_taps_s2    <= r_taps_s1;
    end
  end

  assign w_start_edge = r_start_sync[1] & ~r_start_sync[2];
  assign w_stop_edge  = r_stop_s2 & ~r_stop_s3;
  assign w_start_go   = (r_state == S_IDLE) && w_start_edge;
  assign w_window     = w_start_go || (r_state == S_RUN);
  assign w_coarse_now = w_start_go ? '0 : r_coarse;
  assign w_prev_cap   = w_start_go ? '0 : r_captured;
  assign w_cap        = w_stop_edge & ~w_prev_cap & {NUM_CH{w_window}};
  assign w_all        = &(w_prev_cap | w_cap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_coarse   <= '0;
      r_captured <= '0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_state    <= S_RUN;
            r_coarse   <= COARSE_W'(1);
            r_captured <= w_cap;
            r_timeout  <= 1'b0;
          end
        end
        S_RUN: begin
          r_captured <= r_captured | w_cap;
          r_coarse   <= r_coarse + COARSE_W'(1);
          if (w_all || r_coarse == C_MAX) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_timeout <= ~w_all;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_coarse <= '0;
        end
      endcase
    end
  end

  // Lowest pending channel wins the single push slot
  always_comb begin
    w_push_sel  = '0;
    w_push_data = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (r_pend_valid[c]) begin
        w_push_sel    = '0;
        w_push_sel[c] = 1'b1;
        w_push_data   = r_pend_data[c];
      end
    end
  end
  assign w_push = |r_pend_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_valid <= '0;
      for (int c = 0; c < NUM_CH; c++) r_pend_data[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_cap[c]) begin
          r_pend_valid[c] <= 1'b1;
          r_pend_data[c]  <= {CH_W'(c), w_coarse_now, popcount(r_taps_s2[c*TAPS +: TAPS])};
        end else if (w_push_sel[c]) begin
          r_pend_valid[c] <= 1'b0;
        end
      end
    end
  end

  assign w_pop  = res_valid && res_ready;
  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  // Pending entry is consumed even when the FIFO has to drop it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_wr && w_pop) r_count <= r_count - CW'(1);
      if (w_drop)          r_overflow <= 1'b1;
      else if (w_start_go) r_overflow <= 1'b0;
    end
  end

  assign res_valid  = (r_count != '0);
  assign res_data   = res_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_count = r_count;
  assign busy       = (r_state == S_RUN) || w_start_go;
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_tdc_multi_channel.sv
// Randomised bench for tdc_multi_channel: per-measurement stop schedules are
// turned into expected results, done timing and flags by an arithmetic model.
module tb_tdc_multi_channel;

  localparam int NCH  = 4;
  localparam int CWD  = 5;
  localparam int TP   = 7;
  localparam int FD   = 2;
  localparam int MAXC = (1 << CWD) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [NCH-1:0]  stop;
  logic [NCH*TP-1:0] taps;
  logic            res_valid;
  logic            res_ready;
  logic [9:0]      res_data;
  logic            busy, done, timeout, overflow;
  logic [1:0]      fifo_count;

  tdc_multi_channel #(
    .NUM_CH(NCH), .COARSE_W(CWD), .TAPS(TP), .FIFO_DEPTH(FD)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .taps(taps),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done(done), .timeout(timeout), .overflow(overflow),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observer: popped results, done pulses and busy cycles, sampled mid-cycle
  logic [9:0] got_q[$];
  int done_cnt = 0, done_cyc = 0, busy_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && res_ready) got_q.push_back(res_data);
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (busy) busy_cnt = busy_cnt + 1;
    end
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int         stop_t [NCH];
  logic [6:0] tap_v  [NCH];
  logic [9:0] exp_q[$];
  int         exp_d;
  logic       exp_to;
  int         t0;

  // Channels stopping within the window are captured at their stop time;
  // each cycle the lowest pending channel is emitted.
  task automatic model();
    logic [NCH-1:0] pend;
    int maxt, lo;
    logic all;
    exp_q.delete();
    pend = '0;
    maxt = -1;
    all  = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      if (stop_t[c] >= 0 && stop_t[c] <= MAXC) begin
        if (stop_t[c] > maxt) maxt = stop_t[c];
      end else begin
        all = 1'b0;
      end
    end
    exp_to = !all;
    exp_d  = all ? ((maxt + 1 < 2) ? 2 : maxt + 1) : MAXC + 1;
    for (int k = 0; k <= MAXC + NCH + 1; k++) begin
      if (pend != '0) begin
        lo = 0;
        for (int c = NCH - 1; c >= 0; c--) if (pend[c]) lo = c;
        pend[lo] = 1'b0;
        exp_q.push_back({2'(lo), 5'(stop_t[lo]), 3'($countones(tap_v[lo]))});
      end
      for (int c = 0; c < NCH; c++)
        if (stop_t[c] == k && k <= MAXC) pend[c] = 1'b1;
    end
  endtask

  task automatic drive_meas(input bit glitch);
    for (int c = 0; c < NCH; c++) taps[c*TP +: TP] = tap_v[c];
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    for (int c = 0; c < NCH; c++) if (stop_t[c] == 0) stop[c] = 1'b1;
    for (int k = 1; k <= 44; k++) begin
      @(posedge clk); #1;
      for (int c = 0; c < NCH; c++) if (stop_t[c] == k) stop[c] = 1'b1;
      if (glitch) begin
        if (k == 3)  start   = 1'b0;
        if (k == 10) start   = 1'b1;
        if (k == 6)  stop[0] = 1'b0;
        if (k == 8)  stop[0] = 1'b1;
      end
    end
    start = 1'b0;
    stop  = '0;
  endtask

  task automatic run_meas(input string nm, input bit glitch);
    int bq, bd, bb, n;
    bq = got_q.size();
    bd = done_cnt;
    bb = busy_cnt;
    model();
    drive_meas(glitch);
    repeat (4) @(posedge clk);
    #1;
    n = got_q.size() - bq;
    chk({nm, ".done_cnt"},   32'(done_cnt - bd), 32'(1));
    chk({nm, ".done_cyc"},   32'(done_cyc - t0), 32'(2 + exp_d));
    chk({nm, ".busy_cyc"},   32'(busy_cnt - bb), 32'(exp_d));
    chk({nm, ".timeout"},    32'(timeout), 32'(exp_to));
    chk({nm, ".overflow"},   32'(overflow), 32'(0));
    chk({nm, ".n_results"},  32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++)
      chk({nm, ".result"}, 32'(got_q[bq + i]), 32'(exp_q[i]));
    chk({nm, ".drained"},    32'(res_valid), 32'(0));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".res_valid"},  32'(res_valid), 32'(0));
    chk({nm, ".res_data"},   32'(res_data), 32'(0));
    chk({nm, ".busy"},       32'(busy), 32'(0));
    chk({nm, ".done"},       32'(done), 32'(0));
    chk({nm, ".timeout"},    32'(timeout), 32'(0));
    chk({nm, ".overflow"},   32'(overflow), 32'(0));
    chk({nm, ".fifo_count"}, 32'(fifo_count), 32'(0));
  endtask

  initial begin
    int bq;
    rst = 1'b1; start = 1'b0; stop = '0; taps = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // single stop on ch2
    stop_t = '{-1, -1, 17, -1};
    tap_v  = '{7'h00, 7'h00, 7'b0011111, 7'h00};
    run_meas("single", 1'b0);

    // simultaneous ch0/ch3
    stop_t = '{10, -1, -1, 10};
    tap_v  = '{7'h7f, 7'h00, 7'h00, 7'b0000001};
    run_meas("simul", 1'b0);

    // all captured, last on the final coarse value
    stop_t = '{31, 0, 15, 31};
    tap_v  = '{7'h7f, 7'h00, 7'b0101010, 7'b1110000};
    run_meas("edge31", 1'b0);

    // all captured in the start-detect cycle
    stop_t = '{0, 0, 0, 0};
    tap_v  = '{7'h01, 7'h03, 7'h07, 7'h0f};
    run_meas("all0", 1'b0);

    // bubbled taps, repeated stop[0] and a start pulse during the run
    stop_t = '{4, 8, 12, 20};
    tap_v  = '{7'b1011011, 7'b0111111, 7'b0000011, 7'b1111111};
    run_meas("glitch", 1'b1);

    // backpressure: FIFO fills and the last two entries are dropped
    res_ready = 1'b0;
    stop_t = '{3, 3, 3, 3};
    tap_v  = '{7'b0000111, 7'b0011111, 7'b1111111, 7'b0000001};
    model();
    bq = got_q.size();
    drive_meas(1'b0);
    #1;
    chk("ovf.fifo_count", 32'(fifo_count), 32'(2));
    chk("ovf.overflow",   32'(overflow), 32'(1));
    chk("ovf.res_valid",  32'(res_valid), 32'(1));
    chk("ovf.head",       32'(res_data), 32'(exp_q[0]));
    chk("ovf.timeout",    32'(timeout), 32'(0));
    res_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("ovf.n_results", 32'(got_q.size() - bq), 32'(2));
    if (got_q.size() - bq >= 2) begin
      chk("ovf.res0", 32'(got_q[bq]), 32'(exp_q[0]));
      chk("ovf.res1", 32'(got_q[bq + 1]), 32'(exp_q[1]));
    end
    chk("ovf.drained", 32'(res_valid), 32'(0));

    // overflow clears on the next start
    stop_t = '{5, 6, 7, 8};
    tap_v  = '{7'h11, 7'h22, 7'h44, 7'h08};
    run_meas("ovf_clear", 1'b0);

    // reset in the middle of a run with one entry queued
    res_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    stop[0] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst.pre_count", 32'(fifo_count), 32'(1));
    chk("midrst.pre_busy",  32'(busy), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    start = 1'b0;
    stop  = '0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    stop_t = '{2, 9, -1, 3};
    tap_v  = '{7'h7f, 7'h0f, 7'h00, 7'h01};
    run_meas("fresh", 1'b0);

    // randomised schedules
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < NCH; c++) begin
        stop_t[c] = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 34));
        tap_v[c]  = 7'($urandom_range(0, 127));
      end
      run_meas("rand", 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_multi_channel.md
Name: tdc_multi_channel

Overview:
- Parametrised multi-channel time-to-digital converter core; successor to the single-channel TDC slot of the Tiny Tapeout tile.
- One start event arms a measurement. Each of NUM_CH stop inputs is timestamped relative to start with:
  - a coarse clock-cycle count;
  - a fine interpolation code, taken as the popcount of an externally built tapped delay line snapshot.
- Results are queued in an internal FIFO and drained over a valid/ready interface, to be serialised onto uo_out/uio_out by the tile wrapper.

Parameters:
- NUM_CH, 4: number of stop channels (1..8).
- COARSE_W, 10: coarse counter width; max count 2^COARSE_W-1.
- TAPS, 7: delay-line taps per channel; FINE_W = clog2(TAPS+1).
- FIFO_DEPTH, 8: result FIFO entries, power of two, ≥2.
- CH_W = max(1, clog2(NUM_CH)): local derived parameter, not overridable.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  asynchronous start event (rising edge).
- stop  in  NUM_CH  asynchronous stop events (rising edge per bit).
- taps  in  NUM_CH*TAPS  delay-line tap levels; channel c occupies bits [c*TAPS +: TAPS].
- res_valid  out  1  FIFO head valid.
- res_ready  in  1  consumer accepts head when res_valid&res_ready.
- res_data  out  CH_W+COARSE_W+FINE_W  {channel, coarse, fine}, MSB to LSB.
- busy  out  1  high while state=RUN.
- done  out  1  one-cycle pulse at measurement end.
- timeout  out  1  sticky: coarse counter reached max with channels uncaptured.
- overflow  out  1  sticky: at least one result dropped because FIFO full.
- fifo_count  out  clog2(FIFO_DEPTH)+1  entries held.

Behaviour:
- Reset: every output 0 (res_data 0); state IDLE; FIFO empty; sync/edge flops 0; per-channel captured/pending flags cleared. Reset mid-RUN aborts the measurement with no done pulse and discards all queued results.
- Input synchronisation:
  - start and each stop pass a 2-FF synchroniser, then rising-edge detection.
  - Each channel's taps are sampled on the same edge as that channel's first stop sync stage, then delayed to align with its edge-detect cycle.
  - Edges are not masked after reset. Inputs held high at reset release produce an edge; the bench keeps inputs low ≥3 cycles after release.
- FSM, states IDLE, RUN, DONE:
  - IDLE→RUN on detected start edge. That cycle is coarse 0, and stop edges in that same cycle are captured with coarse=0.
  - In RUN, the coarse value equals the number of cycles since the start-detect cycle.
  - Start edges in RUN or DONE are ignored.
  - RUN→DONE when all channels are captured, or at the cycle coarse = 2^COARSE_W-1. Captures in that last cycle are still taken. Timeout sets iff any channel is uncaptured after that cycle.
  - DONE lasts 1 cycle: done=1, then →IDLE.
  - busy=1 exactly in RUN plus the start-detect cycle.
- Capture:
  - Only the first stop edge per channel per measurement is captured; later edges are ignored.
  - Capture latches {c, coarse, popcount(aligned taps)} into a per-channel pending register.
  - Popcount tolerates thermometer bubbles. All-ones taps gives fine=TAPS; all-zeros gives 0.
- Arbitration:
  - One pending entry is pushed into the FIFO per cycle, lowest channel index first.
  - Simultaneous stops appear in ascending channel order with equal coarse values.
  - Pending registers drain independently of FSM state. done may precede the last push.
- FIFO:
  - First-word fall-through: res_data is valid in the same cycle res_valid=1.
  - Push and pop in the same cycle is allowed when full: count unchanged, no drop.
  - Push when full and no pop: the entry is dropped and overflow=1.
  - The pending entry is consumed regardless of drop.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: timeout and overflow clear on the next detected start edge in IDLE, or on reset.
- Latency: stop pin edge → res_valid is ≥4 cycles (2 sync, 1 edge/capture, 1 push), plus arbitration wait.

Test Plan:
- Single stop: NUM_CH=4. start edge, stop[2] rises 37 cycles after start (same sync path), taps ch2=0b0011111 → one result {2,37,5}; done 1 cycle; timeout=0.
- Simultaneous stops: stop[3] and stop[0] rise on the same clk edge, 10 cycles after start → results ch0 then ch3, both coarse=10, on consecutive cycles; done after both captured.
- Timeout: COARSE_W=4, start, only stop[1] at cycle 5 → done at cycle 16; timeout=1; one result; next start clears timeout.
- Overflow and backpressure: FIFO_DEPTH=2, res_ready=0, 4 channels each stop once → fifo_count=2, overflow=1; raise res_ready → exactly 2 results (ch0, ch1) drain, then res_valid=0.
- Bubble, repeat and ignored start: ch0 taps 0b1011011 → fine=5; second stop[0] edge in same run produces no result; start edge during RUN ignored (coarse values unaffected).
- Reset mid-run: assert rst at coarse=20 with 1 FIFO entry → all outputs 0 asynchronously; after release plus new start, measurement behaves as fresh.
